// File: rtl/quad_step_decoder_pkg.sv
// Shared types and constants for the quadrature step decoder.
// Gray codes are {a, b}; forward rotation is 00 -> 01 -> 11 -> 10 -> 00.
package quad_pkg;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  localparam logic [1:0] G00 = 2'b00;
  localparam logic [1:0] G01 = 2'b01;
  localparam logic [1:0] G11 = 2'b11;
  localparam logic [1:0] G10 = 2'b10;

  localparam int unsigned ResFull    = 4;
  localparam int unsigned ResHalf    = 2;
  localparam int unsigned ResQuarter = 1;

  localparam int unsigned CntWidth = 4;

  function automatic logic res_legal(int unsigned res);
    return (res == ResFull) || (res == ResHalf) || (res == ResQuarter);
  endfunction

  // Forward successor of a Gray state.
  function automatic logic [1:0] gray_next(logic [1:0] g);
    logic [1:0] n;
    n = G00;
    unique case (g)
      G00: n = G01;
      G01: n = G11;
      G11: n = G10;
      G10: n = G00;
      default: n = G00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Encoder-facing signal bundle: phase inputs and error clear in, step pulses and status out.
interface quad_step_decoder_if;
  logic a_in;
  logic b_in;
  logic clear_err;
  logic up;
  logic down;
  logic err;
  logic ready;

  modport master (
    output a_in, b_in, clear_err,
    input  up, down, err, ready
  );

  modport slave (
    input  a_in, b_in, clear_err,
    output up, down, err, ready
  );
endinterface

// File: rtl/quad_step_decoder_phase_filter.sv
// Two-flop synchronizer followed by a persistence filter: the filtered bit only follows
// the synchronized input after it has differed for FILTER_LEN consecutive cycles.
module phase_filter
  import quad_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic in_i,
  output logic f_o,
  output logic settled_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(FILTER_LEN - 1);

  logic                s1_q, s2_q;
  logic                f_q, f_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q + CntWidth'(1);
    if (s2_q == f_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      f_d   = s2_q;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= in_i;
      s2_q  <= s1_q;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign f_o       = f_q;
  assign settled_o = (s2_q == f_q);

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: filters both phases, decodes Gray transitions into registered
// up/down step pulses at the chosen resolution, and flags two-bit jumps in a sticky err.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned RES        = 4
) (
  input logic             clk,
  input logic             reset,
  quad_step_decoder_if.slave bus
);

  if (!res_legal(RES)) begin : gen_bad_res
    $error("quad_step_decoder: RES must be 1, 2 or 4");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : gen_bad_filter_len
    $error("quad_step_decoder: FILTER_LEN must be in 1..15");
  end

  logic       f_a, f_b, settled_a, settled_b;
  logic [1:0] cur;
  logic [1:0] prev_q, prev_d;
  state_e     state_q, state_d;
  logic       up_q, up_d, down_q, down_d, err_q, err_d;
  logic       fwd, rev, gate;

  phase_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt_a (
    .clk_i    (clk),
    .reset_i  (reset),
    .in_i     (bus.a_in),
    .f_o      (f_a),
    .settled_o(settled_a)
  );

  phase_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt_b (
    .clk_i    (clk),
    .reset_i  (reset),
    .in_i     (bus.b_in),
    .f_o      (f_b),
    .settled_o(settled_b)
  );

  assign cur = {f_a, f_b};
  assign fwd = (cur == gray_next(prev_q));
  assign rev = (prev_q == gray_next(cur));

  always_comb begin
    gate = 1'b1;
    if (RES == ResHalf) begin
      gate = (cur == G00) || (cur == G11);
    end else if (RES == ResQuarter) begin
      gate = (cur == G00);
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = cur;
    up_d    = 1'b0;
    down_d  = 1'b0;
    err_d   = err_q;
    if (bus.clear_err) begin
      err_d = 1'b0;
    end
    unique case (state_q)
      StInit: begin
        if (settled_a && settled_b) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (cur != prev_q) begin
          if (fwd) begin
            up_d = gate;
          end else if (rev) begin
            down_d = gate;
          end else begin
            // Both bits moved at once; setting wins over a coincident clear.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
      prev_q  <= G00;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      up_q    <= up_d;
      down_q  <= down_d;
      err_q   <= err_d;
    end
  end

  assign bus.up    = up_q;
  assign bus.down  = down_q;
  assign bus.err   = err_q;
  assign bus.ready = (state_q == StRun);

endmodule
